// File: rtl/emif_amm_pkg.sv
// Shared types and default widths for the EMIF Avalon-MM requester.
// Carries no logic: parameters, FSM encoding and a credit-counter width helper.
package emif_amm_pkg;

   localparam int DEF_ADDR_W          = 28;
   localparam int DEF_DATA_W          = 576;
   localparam int DEF_MAX_OUTSTANDING = 16;

   localparam int                     AMM_BURST_W   = 7;
   localparam logic [AMM_BURST_W-1:0] AMM_BURST_ONE = 7'd1;

   typedef enum logic {
      CAL_WAIT = 1'b0,
      RUN      = 1'b1
   } state_t;

   // Counter wide enough to hold the value 'depth' itself, not just depth-1.
   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/emif_rsp_fifo.sv
// Read-response FIFO with occupancy count; pop_vld rises the cycle after a push into empty.
// Latency 1 cycle; a push into a full FIFO is only taken alongside a pop, otherwise dropped.
module emif_rsp_fifo
   import emif_amm_pkg::*;
#(
   parameter int DEPTH = DEF_MAX_OUTSTANDING,
   parameter int WIDTH = DEF_DATA_W,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = cnt_w(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_vld,
   input  logic [WIDTH-1:0] push_dat,
   output logic             pop_vld,
   input  logic             pop_rdy,
   output logic [WIDTH-1:0] pop_dat,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             full;
   logic             push;
   logic             pop;

   assign full    = (count == CW'(DEPTH));
   assign pop_vld = (count != '0);
   assign pop     = pop_vld & pop_rdy;
   assign push    = push_vld & (~full | pop);
   assign pop_dat = mem[rd_ptr];

   // Storage is not reset; only the pointers and count define validity.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_dat;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(push_vld && full && !pop));

endmodule

// File: rtl/emif_amm_requester.sv
// EMIF Avalon-MM requester: one holding register onto the bus, 1-cycle request-to-bus latency.
// req_ready drops while a held command waits; reads stall when MAX_OUTSTANDING credits are in use.
module emif_amm_requester
   import emif_amm_pkg::*;
#(
   parameter int ADDR_W          = DEF_ADDR_W,
   parameter int DATA_W          = DEF_DATA_W,
   parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
   input  logic                   emif_usr_clk,
   input  logic                   emif_usr_reset_n,
   input  logic                   local_cal_success,

   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_write,
   input  logic [ADDR_W-1:0]      req_addr,
   input  logic [DATA_W-1:0]      req_wdata,

   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [DATA_W-1:0]      rsp_rdata,

   input  logic                   amm_ready_0,
   output logic                   amm_read_0,
   output logic                   amm_write_0,
   output logic [ADDR_W-1:0]      amm_address_0,
   output logic [DATA_W-1:0]      amm_writedata_0,
   output logic [AMM_BURST_W-1:0] amm_burstcount_0,
   input  logic                   amm_readdatavalid_0,
   input  logic [DATA_W-1:0]      amm_readdata_0,

   output logic                   busy,
   output logic                   err_unexp_rdv
);

   localparam int          CW         = cnt_w(MAX_OUTSTANDING);
   localparam logic [CW:0] CREDIT_MAX = (CW+1)'(MAX_OUTSTANDING);

   if (MAX_OUTSTANDING < 2 || (MAX_OUTSTANDING & (MAX_OUTSTANDING - 1)) != 0) begin : g_bad_credits
      $error("MAX_OUTSTANDING must be a power of two and at least 2");
   end

   state_t              state;
   logic                cmd_vld;
   logic                cmd_write;
   logic [ADDR_W-1:0]   cmd_addr;
   logic [DATA_W-1:0]   cmd_wdata;

   logic [CW-1:0]       inflight;
   logic [CW-1:0]       fifo_count;
   logic [CW:0]         credit_used;
   logic                credit_ok;
   logic                fire;
   logic                rd_fire;
   logic                accept;
   logic                rdv_exp;
   logic                rdv_unexp;

   // Responses already buffered still hold credit until the user pops them,
   // which is what keeps the FIFO from ever overflowing.
   assign credit_used = {1'b0, inflight} + {1'b0, fifo_count};
   assign credit_ok   = (credit_used < CREDIT_MAX);

   assign fire      = cmd_vld & amm_ready_0 & (cmd_write | credit_ok);
   assign rd_fire   = fire & ~cmd_write;
   assign req_ready = local_cal_success & (state == RUN) & (~cmd_vld | fire);
   assign accept    = req_valid & req_ready;

   assign rdv_exp   = amm_readdatavalid_0 & (inflight != '0);
   assign rdv_unexp = amm_readdatavalid_0 & (inflight == '0);

   assign amm_write_0      = cmd_vld & cmd_write;
   assign amm_read_0       = cmd_vld & ~cmd_write & credit_ok;
   assign amm_address_0    = cmd_addr;
   assign amm_writedata_0  = cmd_wdata;
   assign amm_burstcount_0 = AMM_BURST_ONE;

   assign busy = cmd_vld | (inflight != '0) | (fifo_count != '0);

   always_ff @(posedge emif_usr_clk or negedge emif_usr_reset_n) begin
      if (!emif_usr_reset_n) begin
         state <= CAL_WAIT;
      end else begin
         case (state)
            CAL_WAIT: if (local_cal_success)  state <= RUN;
            RUN:      if (!local_cal_success) state <= CAL_WAIT;
            default:                          state <= CAL_WAIT;
         endcase
      end
   end

   // A command accepted in its predecessor's fire cycle overwrites it directly.
   always_ff @(posedge emif_usr_clk or negedge emif_usr_reset_n) begin
      if (!emif_usr_reset_n) begin
         cmd_vld   <= 1'b0;
         cmd_write <= 1'b0;
         cmd_addr  <= '0;
         cmd_wdata <= '0;
      end else if (accept) begin
         cmd_vld   <= 1'b1;
         cmd_write <= req_write;
         cmd_addr  <= req_addr;
         cmd_wdata <= req_wdata;
      end else if (fire) begin
         cmd_vld   <= 1'b0;
      end
   end

   always_ff @(posedge emif_usr_clk or negedge emif_usr_reset_n) begin
      if (!emif_usr_reset_n) begin
         inflight <= '0;
      end else begin
         case ({rd_fire, rdv_exp})
            2'b10:   inflight <= inflight + CW'(1);
            2'b01:   inflight <= inflight - CW'(1);
            default: inflight <= inflight;
         endcase
      end
   end

   always_ff @(posedge emif_usr_clk or negedge emif_usr_reset_n) begin
      if (!emif_usr_reset_n) begin
         err_unexp_rdv <= 1'b0;
      end else if (rdv_unexp) begin
         err_unexp_rdv <= 1'b1;
      end
   end

   emif_rsp_fifo #(
      .DEPTH (MAX_OUTSTANDING),
      .WIDTH (DATA_W)
   ) u_rsp_fifo (
      .clk      (emif_usr_clk),
      .rst_n    (emif_usr_reset_n),
      .push_vld (rdv_exp),
      .push_dat (amm_readdata_0),
      .pop_vld  (rsp_valid),
      .pop_rdy  (rsp_ready),
      .pop_dat  (rsp_rdata),
      .count    (fifo_count)
   );

   a_read_hold: assert property (@(posedge emif_usr_clk) disable iff (!emif_usr_reset_n)
      (amm_read_0 && !amm_ready_0) |=> (amm_read_0 && $stable(amm_address_0)));

   a_write_hold: assert property (@(posedge emif_usr_clk) disable iff (!emif_usr_reset_n)
      (amm_write_0 && !amm_ready_0) |=>
         (amm_write_0 && $stable(amm_address_0) && $stable(amm_writedata_0)));

   a_credit_bound: assert property (@(posedge emif_usr_clk) disable iff (!emif_usr_reset_n)
      credit_used <= CREDIT_MAX);

endmodule

// File: tb/tb_emif_amm_requester.sv
// Bench for emif_amm_requester: bus commands and read responses go through expectation queues.
module tb_emif_amm_requester;

   localparam int AW = 28;
   localparam int DW = 576;
   localparam int MO = 16;

   typedef struct {
      logic          w;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } cmd_s;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cal;
   logic          req_valid;
   logic          req_ready;
   logic          req_write;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_rdata;
   logic          amm_ready;
   logic          amm_read;
   logic          amm_write;
   logic [AW-1:0] amm_address;
   logic [DW-1:0] amm_writedata;
   logic [6:0]    amm_burstcount;
   logic          amm_rdv;
   logic [DW-1:0] amm_rdata;
   logic          busy;
   logic          err;

   int            total = 0;
   int            bad   = 0;
   cmd_s          exp_cmd[$];
   logic [DW-1:0] exp_rsp[$];

   always #5 clk = ~clk;

   emif_amm_requester #(
      .ADDR_W          (AW),
      .DATA_W          (DW),
      .MAX_OUTSTANDING (MO)
   ) dut (
      .emif_usr_clk        (clk),
      .emif_usr_reset_n    (rst_n),
      .local_cal_success   (cal),
      .req_valid           (req_valid),
      .req_ready           (req_ready),
      .req_write           (req_write),
      .req_addr            (req_addr),
      .req_wdata           (req_wdata),
      .rsp_valid           (rsp_valid),
      .rsp_ready           (rsp_ready),
      .rsp_rdata           (rsp_rdata),
      .amm_ready_0         (amm_ready),
      .amm_read_0          (amm_read),
      .amm_write_0         (amm_write),
      .amm_address_0       (amm_address),
      .amm_writedata_0     (amm_writedata),
      .amm_burstcount_0    (amm_burstcount),
      .amm_readdatavalid_0 (amm_rdv),
      .amm_readdata_0      (amm_rdata),
      .busy                (busy),
      .err_unexp_rdv       (err)
   );

   function automatic logic [DW-1:0] mk(input logic [31:0] k);
      return {18{k}};
   endfunction

   // Scoreboard: every bus handshake and every response pop is checked against the queues.
   cmd_s          mon_c;
   logic [DW-1:0] mon_r;
   always @(negedge clk) begin
      if (rst_n && amm_ready && (amm_read || amm_write)) begin
         total++;
         if (exp_cmd.size() == 0) begin
            bad++;
            $display("FAIL bus_fire: unexpected command w=%0b addr=%h", amm_write, amm_address);
         end else begin
            mon_c = exp_cmd.pop_front();
            if (amm_write !== mon_c.w || amm_address !== mon_c.a ||
                (mon_c.w && amm_writedata !== mon_c.d)) begin
               bad++;
               $display("FAIL bus_cmd: got w=%0b addr=%h data=%h, want w=%0b addr=%h data=%h",
                        amm_write, amm_address, amm_writedata[31:0],
                        mon_c.w, mon_c.a, mon_c.d[31:0]);
            end
         end
      end
      if (rst_n && rsp_valid && rsp_ready) begin
         total++;
         if (exp_rsp.size() == 0) begin
            bad++;
            $display("FAIL rsp_pop: unexpected response data=%h", rsp_rdata[31:0]);
         end else begin
            mon_r = exp_rsp.pop_front();
            if (rsp_rdata !== mon_r) begin
               bad++;
               $display("FAIL rsp_data: got %h want %h", rsp_rdata[31:0], mon_r[31:0]);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      cmd_s c;
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (req_ready === 1'b1) begin
            c.w = w;
            c.a = a;
            c.d = d;
            exp_cmd.push_back(c);
            step();
            return;
         end
         step();
      end
      total++;
      bad++;
      $display("FAIL send_timeout: req_ready never 1 for addr=%h", a);
   endtask

   task automatic test_reset();
      repeat (2) step();
      @(negedge clk);
      total++;
      if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || amm_read !== 1'b0 ||
          amm_write !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
         bad++;
         $display("FAIL reset_ctrl: got rdy=%0b rv=%0b rd=%0b wr=%0b busy=%0b err=%0b, want all 0",
                  req_ready, rsp_valid, amm_read, amm_write, busy, err);
      end
      total++;
      if (amm_address !== '0 || amm_writedata !== '0 || amm_burstcount !== 7'd1) begin
         bad++;
         $display("FAIL reset_bus: got addr=%h data=%h bc=%0d, want 0 0 1",
                  amm_address, amm_writedata[31:0], amm_burstcount);
      end
      step();
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (req_ready !== 1'b0) begin
         bad++;
         $display("FAIL reset_calwait: req_ready got %0b want 0", req_ready);
      end
      step();
      @(negedge clk);
      total++;
      if (req_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_run: req_ready got %0b want 1", req_ready);
      end
      step();
   endtask

   task automatic test_back_to_back();
      cmd_s c;
      logic exp_w;
      amm_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (i < 4) begin
            req_valid = 1'b1;
            req_write = 1'b1;
            req_addr  = AW'(28'h100 + i);
            req_wdata = mk(32'hA000_0000 + 32'(i));
         end else begin
            req_valid = 1'b0;
         end
         @(negedge clk);
         if (i < 4) begin
            total++;
            if (req_ready !== 1'b1) begin
               bad++;
               $display("FAIL b2b_ready: cycle %0d req_ready got %0b want 1", i, req_ready);
            end else begin
               c.w = 1'b1;
               c.a = req_addr;
               c.d = req_wdata;
               exp_cmd.push_back(c);
            end
         end
         exp_w = (i >= 1 && i <= 4);
         total++;
         if (amm_write !== exp_w) begin
            bad++;
            $display("FAIL b2b_write: cycle %0d amm_write got %0b want %0b", i, amm_write, exp_w);
         end
         step();
      end
   endtask

   task automatic test_read_wait();
      amm_ready = 1'b0;
      rsp_ready = 1'b1;
      send(1'b0, 28'h123, '0);
      req_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         total++;
         if (amm_read !== 1'b1 || amm_address !== 28'h123 || req_ready !== 1'b0) begin
            bad++;
            $display("FAIL rd_hold: cycle %0d rd=%0b addr=%h rdy=%0b, want 1 123 0",
                     i, amm_read, amm_address, req_ready);
         end
         step();
      end
      amm_ready = 1'b1;
      @(negedge clk);
      total++;
      if (amm_read !== 1'b1) begin
         bad++;
         $display("FAIL rd_fire: amm_read got %0b want 1", amm_read);
      end
      step();
      @(negedge clk);
      total++;
      if (amm_read !== 1'b0 || dut.inflight !== 1 || busy !== 1'b1) begin
         bad++;
         $display("FAIL rd_inflight: rd=%0b inflight=%0d busy=%0b, want 0 1 1",
                  amm_read, dut.inflight, busy);
      end
      step();
      amm_rdv   = 1'b1;
      amm_rdata = mk(32'h5555_0123);
      exp_rsp.push_back(amm_rdata);
      step();
      amm_rdv = 1'b0;
      @(negedge clk);
      total++;
      if (rsp_valid !== 1'b1) begin
         bad++;
         $display("FAIL rd_rsp_valid: got %0b want 1", rsp_valid);
      end
      step();
      @(negedge clk);
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL rd_idle: busy got %0b want 0", busy);
      end
      step();
   endtask

   task automatic test_rsp_order();
      logic exp_v;
      amm_ready = 1'b1;
      rsp_ready = 1'b1;
      for (int i = 0; i < 3; i++) send(1'b0, AW'(28'h200 + i), '0);
      req_valid = 1'b0;
      step();
      for (int i = 0; i < 5; i++) begin
         if (i < 3) begin
            amm_rdv   = 1'b1;
            amm_rdata = mk(32'hD100_0000 + 32'(i));
            exp_rsp.push_back(amm_rdata);
         end else begin
            amm_rdv = 1'b0;
         end
         @(negedge clk);
         exp_v = (i >= 1 && i <= 3);
         total++;
         if (rsp_valid !== exp_v) begin
            bad++;
            $display("FAIL order_valid: cycle %0d rsp_valid got %0b want %0b", i, rsp_valid, exp_v);
         end
         if (i == 4) begin
            total++;
            if (busy !== 1'b0) begin
               bad++;
               $display("FAIL order_busy: busy got %0b want 0", busy);
            end
         end
         step();
      end
   endtask

   task automatic test_credit_limit();
      amm_ready = 1'b1;
      rsp_ready = 1'b0;
      for (int k = 0; k < MO + 1; k++) send(1'b0, AW'(28'h300 + k), '0);
      req_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++;
         if (amm_read !== 1'b0 || req_ready !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL credit_stall: cycle %0d rd=%0b rdy=%0b busy=%0b, want 0 0 1",
                     i, amm_read, req_ready, busy);
         end
         step();
      end
      amm_rdv   = 1'b1;
      amm_rdata = mk(32'hC000_0000);
      exp_rsp.push_back(amm_rdata);
      step();
      amm_rdv = 1'b0;
      @(negedge clk);
      total++;
      if (amm_read !== 1'b0 || rsp_valid !== 1'b1) begin
         bad++;
         $display("FAIL credit_buffered: rd=%0b rv=%0b, want 0 1", amm_read, rsp_valid);
      end
      step();
      rsp_ready = 1'b1;
      @(negedge clk);
      total++;
      if (amm_read !== 1'b0) begin
         bad++;
         $display("FAIL credit_prepop: amm_read got %0b want 0", amm_read);
      end
      step();
      rsp_ready = 1'b0;
      @(negedge clk);
      total++;
      if (amm_read !== 1'b1 || amm_address !== AW'(28'h300 + MO)) begin
         bad++;
         $display("FAIL credit_release: rd=%0b addr=%h, want 1 %h", amm_read, amm_address,
                  AW'(28'h300 + MO));
      end
      step();
      rsp_ready = 1'b1;
      for (int k = 0; k < MO; k++) begin
         amm_rdv   = 1'b1;
         amm_rdata = mk(32'hC100_0000 + 32'(k));
         exp_rsp.push_back(amm_rdata);
         step();
      end
      amm_rdv = 1'b0;
      repeat (2) step();
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
         bad++;
         $display("FAIL credit_drain: busy=%0b rv=%0b, want 0 0", busy, rsp_valid);
      end
      step();
      rsp_ready = 1'b0;
   endtask

   task automatic test_unexp_rdv();
      @(negedge clk);
      total++;
      if (err !== 1'b0) begin
         bad++;
         $display("FAIL unexp_pre: err got %0b want 0", err);
      end
      step();
      amm_rdv   = 1'b1;
      amm_rdata = mk(32'hDEAD_BEEF);
      step();
      amm_rdv = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++;
         if (err !== 1'b1 || rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL unexp_sticky: cycle %0d err=%0b rv=%0b, want 1 0", i, err, rsp_valid);
         end
         step();
      end
   endtask

   task automatic test_reset_midflight();
      rst_n = 1'b0;
      @(negedge clk);
      total++;
      if (err !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL mid_reset_clear: err=%0b busy=%0b, want 0 0", err, busy);
      end
      step();
      rst_n     = 1'b1;
      amm_ready = 1'b1;
      step();
      send(1'b0, 28'h400, '0);
      req_valid = 1'b0;
      step();
      @(negedge clk);
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL mid_inflight: busy got %0b want 1", busy);
      end
      step();
      rst_n = 1'b0;
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || amm_read !== 1'b0) begin
         bad++;
         $display("FAIL mid_abandon: busy=%0b rd=%0b, want 0 0", busy, amm_read);
      end
      step();
      rst_n     = 1'b1;
      amm_rdv   = 1'b1;
      amm_rdata = mk(32'h0BAD_0400);
      step();
      amm_rdv = 1'b0;
      @(negedge clk);
      total++;
      if (err !== 1'b1 || rsp_valid !== 1'b0) begin
         bad++;
         $display("FAIL mid_late_rdv: err=%0b rv=%0b, want 1 0", err, rsp_valid);
      end
      step();
   endtask

   task automatic test_cal_drop();
      amm_ready = 1'b0;
      send(1'b1, 28'h500, mk(32'hBEEF_0500));
      req_addr  = 28'h501;
      req_wdata = mk(32'hBEEF_0501);
      cal       = 1'b0;
      @(negedge clk);
      total++;
      if (req_ready !== 1'b0 || amm_write !== 1'b1) begin
         bad++;
         $display("FAIL cal_drop: rdy=%0b wr=%0b, want 0 1", req_ready, amm_write);
      end
      step();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         total++;
         if (req_ready !== 1'b0 || amm_write !== 1'b1 || amm_address !== 28'h500) begin
            bad++;
            $display("FAIL cal_hold: cycle %0d rdy=%0b wr=%0b addr=%h, want 0 1 500",
                     i, req_ready, amm_write, amm_address);
         end
         step();
      end
      amm_ready = 1'b1;
      step();
      @(negedge clk);
      total++;
      if (amm_write !== 1'b0 || req_ready !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL cal_fired: wr=%0b rdy=%0b busy=%0b, want 0 0 0", amm_write, req_ready, busy);
      end
      step();
      req_valid = 1'b0;
      cal       = 1'b1;
      step();
      @(negedge clk);
      total++;
      if (req_ready !== 1'b1) begin
         bad++;
         $display("FAIL cal_resume: req_ready got %0b want 1", req_ready);
      end
      step();
   endtask

   initial begin
      rst_n     = 1'b0;
      cal       = 1'b1;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      rsp_ready = 1'b0;
      amm_ready = 1'b1;
      amm_rdv   = 1'b0;
      amm_rdata = '0;

      test_reset();
      test_back_to_back();
      test_read_wait();
      test_rsp_order();
      test_credit_limit();
      test_unexp_rdv();
      test_reset_midflight();
      test_cal_drop();

      total++;
      if (exp_cmd.size() != 0 || exp_rsp.size() != 0) begin
         bad++;
         $display("FAIL leftover: cmds=%0d rsps=%0d still expected, want 0 0",
                  exp_cmd.size(), exp_rsp.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
